// File: rtl/tgate_switch_seq.sv
// -----------------------------------------------------------------------------
// tgate_switch_seq
//
// Break-before-make sequencer for a pair of CMOS transmission gates. A new
// channel is only connected after an all-off dead time of DEAD_CYC cycles, so
// two channels can never conduct at once. Disconnects take effect immediately.
//
// Parameters
//   DEAD_CYC   : number of all-off dead-time cycles (1..15)
//
// Ports
//   clk        : clock, all state updates on its rising edge
//   rstn       : asynchronous active-low reset
//   req_valid  : a switch request is present
//   req_sel    : target channel (0 or 1)
//   req_en     : 1 = connect the target channel, 0 = disconnect everything
//   req_ready  : a request can be accepted this cycle (low during dead time)
//   ngate      : nmos gate control per channel, active-high
//   pgate      : pmos gate control per channel, active-low (always ~ngate)
//   active_sel : channel currently connected, or last targeted
//   connected  : a channel is conducting
//   busy       : the dead-time interval is in progress
// -----------------------------------------------------------------------------
module tgate_switch_seq #(
   parameter int unsigned DEAD_CYC = 3
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       req_valid,
   input  logic       req_sel,
   input  logic       req_en,
   output logic       req_ready,
   output logic [1:0] ngate,
   output logic [1:0] pgate,
   output logic       active_sel,
   output logic       connected,
   output logic       busy
);

   typedef enum logic [1:0] {
      S_OFF   = 2'b00,
      S_BREAK = 2'b01,
      S_ON    = 2'b10
   } state_t;

   // The counter holds "cycles remaining minus one", so a load of DEAD_CYC-1
   // makes the channel exactly DEAD_CYC edges after the accepting edge.
   localparam logic [3:0] CNT_LOAD = 4'(DEAD_CYC - 1);

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [1:0] ngate_nxt;
   logic       sel_nxt;
   logic       armed;
   logic       accept;

   // req_ready already reads 1 on the edge that releases reset; armed blocks
   // acceptance on that one edge so release is purely synchronous.
   assign accept = req_valid & req_ready & armed;

   // NOTE: every variable driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ngate_nxt = ngate;
      sel_nxt   = active_sel;
      case (state)
         S_OFF: begin
            // A disconnect while already off is a no-op.
            if (accept && req_en) begin
               ngate_nxt = 2'b00;
               sel_nxt   = req_sel;
               cnt_nxt   = CNT_LOAD;
               state_nxt = S_BREAK;
            end
         end
         S_BREAK: begin
            if (cnt == 4'd0) begin
               state_nxt = S_ON;
               ngate_nxt = active_sel ? 2'b10 : 2'b01;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         S_ON: begin
            if (accept) begin
               if (!req_en) begin
                  // Opening a switch needs no dead time; active_sel is kept.
                  ngate_nxt = 2'b00;
                  state_nxt = S_OFF;
               end else if (req_sel != active_sel) begin
                  ngate_nxt = 2'b00;
                  sel_nxt   = req_sel;
                  cnt_nxt   = CNT_LOAD;
                  state_nxt = S_BREAK;
               end
               // Same channel again: registers are simply left as they are,
               // so the conducting gate never glitches.
            end
         end
         default: begin
            state_nxt = S_OFF;
            ngate_nxt = 2'b00;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= S_OFF;
         cnt        <= 4'd0;
         armed      <= 1'b0;
         ngate      <= 2'b00;
         pgate      <= 2'b11;
         active_sel <= 1'b0;
         connected  <= 1'b0;
         busy       <= 1'b0;
         req_ready  <= 1'b1;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         armed      <= 1'b1;
         ngate      <= ngate_nxt;
         // Both gates of a channel come from the same next-state value and
         // switch on the same edge, so there is no complementary skew.
         pgate      <= ~ngate_nxt;
         active_sel <= sel_nxt;
         connected  <= (state_nxt == S_ON);
         busy       <= (state_nxt == S_BREAK);
         req_ready  <= (state_nxt != S_BREAK);
      end
   end

endmodule

// File: tb/tb_tgate_switch_seq.sv
// -----------------------------------------------------------------------------
// tb_tgate_switch_seq
//
// Self-checking bench for tgate_switch_seq. One instance uses DEAD_CYC=3 and
// is driven from a table of {inputs, expected outputs}; expectations go
// through a scoreboard queue. A second instance with DEAD_CYC=1 covers the
// minimum dead time. Gate complementarity is checked on every cycle.
// -----------------------------------------------------------------------------
module tb_tgate_switch_seq;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   // DEAD_CYC = 3 instance
   logic       req_valid, req_sel, req_en;
   logic       req_ready, active_sel, connected, busy;
   logic [1:0] ngate, pgate;

   // DEAD_CYC = 1 instance
   logic       m_valid, m_sel, m_en;
   logic       m_ready, m_active_sel, m_connected, m_busy;
   logic [1:0] m_ngate, m_pgate;

   tgate_switch_seq #(.DEAD_CYC(3)) u_dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_sel(req_sel), .req_en(req_en),
      .req_ready(req_ready), .ngate(ngate), .pgate(pgate),
      .active_sel(active_sel), .connected(connected), .busy(busy)
   );

   tgate_switch_seq #(.DEAD_CYC(1)) u_dut_min (
      .clk(clk), .rstn(rstn),
      .req_valid(m_valid), .req_sel(m_sel), .req_en(m_en),
      .req_ready(m_ready), .ngate(m_ngate), .pgate(m_pgate),
      .active_sel(m_active_sel), .connected(m_connected), .busy(m_busy)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       v, s, e;       // stimulus
      logic [1:0] ng;            // expected outputs after the edge
      logic       b, c, r, as;
   } vec_t;

   typedef struct {
      int         idx;
      logic [1:0] ng;
      logic       b, c, r, as;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];

   task automatic add(input logic v, s, e, input logic [1:0] ng, input logic b, c, r, as);
      vec_t t;
      t = '{v: v, s: s, e: e, ng: ng, b: b, c: c, r: r, as: as};
      tbl.push_back(t);
   endtask

   // Continuous gate-safety checks on both instances.
   always @(negedge clk) begin
      logic [1:0] inv_a, inv_b;
      inv_a = ~ngate;
      inv_b = ~m_ngate;
      check("pgate_eq_not_ngate", pgate, inv_a);
      check("ngate_never_11", ngate == 2'b11, 1'b0);
      check("min_pgate_eq_not_ngate", m_pgate, inv_b);
      check("min_ngate_never_11", m_ngate == 2'b11, 1'b0);
   end

   task automatic check_reset_vals(input string tag);
      check({tag, " ngate"}, ngate, 2'b00);
      check({tag, " pgate"}, pgate, 2'b11);
      check({tag, " busy"}, busy, 1'b0);
      check({tag, " connected"}, connected, 1'b0);
      check({tag, " active_sel"}, active_sel, 1'b0);
      check({tag, " req_ready"}, req_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t ex;
      req_valid = 0; req_sel = 0; req_en = 0;
      m_valid = 0; m_sel = 0; m_en = 0;

      //   v  s  e  ngate  b  c  r  as
      add(0, 0, 0, 2'b00, 0, 0, 1, 0); // 0  idle in OFF
      add(1, 1, 1, 2'b00, 1, 0, 0, 1); // 1  connect ch1 accepted
      add(0, 0, 0, 2'b00, 1, 0, 0, 1); // 2  dead time
      add(0, 0, 0, 2'b00, 1, 0, 0, 1); // 3  dead time
      add(0, 0, 0, 2'b10, 0, 1, 1, 1); // 4  make at accept+3
      add(1, 1, 1, 2'b10, 0, 1, 1, 1); // 5  redundant: no change
      add(1, 0, 1, 2'b00, 1, 0, 0, 0); // 6  switch to ch0: break
      add(1, 1, 1, 2'b00, 1, 0, 0, 0); // 7  held off during BREAK
      add(1, 1, 1, 2'b00, 1, 0, 0, 0); // 8  still held off
      add(1, 1, 1, 2'b01, 0, 1, 1, 0); // 9  make ch0, request not taken
      add(1, 1, 1, 2'b00, 1, 0, 0, 1); // 10 held request accepted on first ON
      add(0, 0, 0, 2'b00, 1, 0, 0, 1); // 11
      add(0, 0, 0, 2'b00, 1, 0, 0, 1); // 12
      add(0, 0, 0, 2'b10, 0, 1, 1, 1); // 13 ON ch1
      add(1, 0, 1, 2'b00, 1, 0, 0, 0); // 14 switch to ch0
      add(0, 0, 0, 2'b00, 1, 0, 0, 0); // 15
      add(0, 0, 0, 2'b00, 1, 0, 0, 0); // 16
      add(0, 0, 0, 2'b01, 0, 1, 1, 0); // 17 ON ch0
      add(1, 0, 0, 2'b00, 0, 0, 1, 0); // 18 disconnect: immediate OFF
      add(1, 1, 0, 2'b00, 0, 0, 1, 0); // 19 disconnect in OFF: no-op
      add(0, 0, 0, 2'b00, 0, 0, 1, 0); // 20 idle

      // Reset values while reset is held.
      repeat (3) @(posedge clk);
      #1 check_reset_vals("in_reset");

      // Release with a request already present: the release edge must not take it.
      @(negedge clk);
      rstn = 1; req_valid = 1; req_en = 1; req_sel = 1;
      @(posedge clk);
      #1;
      check("release_edge busy", busy, 1'b0);
      check("release_edge active_sel", active_sel, 1'b0);
      check("release_edge req_ready", req_ready, 1'b1);

      // Table-driven main sequence through the scoreboard.
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         req_valid = tbl[i].v; req_sel = tbl[i].s; req_en = tbl[i].e;
         sb.push_back('{idx: i, ng: tbl[i].ng, b: tbl[i].b, c: tbl[i].c,
                        r: tbl[i].r, as: tbl[i].as});
         @(posedge clk);
         #1;
         ex = sb.pop_front();
         check($sformatf("v%0d ngate", ex.idx), ngate, ex.ng);
         check($sformatf("v%0d busy", ex.idx), busy, ex.b);
         check($sformatf("v%0d connected", ex.idx), connected, ex.c);
         check($sformatf("v%0d req_ready", ex.idx), req_ready, ex.r);
         check($sformatf("v%0d active_sel", ex.idx), active_sel, ex.as);
      end

      // Reset in the middle of BREAK.
      @(negedge clk);
      req_valid = 1; req_en = 1; req_sel = 1;
      @(posedge clk);
      #1 check("rb accept busy", busy, 1'b1);
      @(negedge clk);
      req_valid = 0;
      #2 rstn = 0;
      #1 check_reset_vals("rst_mid_break");
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("rb no_make c%0d", k), ngate, 2'b00);
      end
      rstn = 1; req_valid = 1; req_en = 1; req_sel = 0;
      @(posedge clk);
      #1 check("rb release_edge busy", busy, 1'b0);
      @(posedge clk);
      #1;
      check("rb re-accept busy", busy, 1'b1);
      check("rb re-accept ngate", ngate, 2'b00);
      @(negedge clk);
      req_valid = 0;
      for (int k = 1; k < 3; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("rb dead+%0d busy", k), busy, 1'b1);
         check($sformatf("rb dead+%0d ngate", k), ngate, 2'b00);
      end
      @(posedge clk);
      #1;
      check("rb make ngate", ngate, 2'b01);
      check("rb make connected", connected, 1'b1);

      // Reset while ON.
      @(negedge clk);
      #2 rstn = 0;
      #1 check_reset_vals("rst_mid_on");
      repeat (2) @(negedge clk);
      check("ron stays off", ngate, 2'b00);
      rstn = 1;
      @(posedge clk);

      // Minimum dead time on the DEAD_CYC=1 instance.
      @(negedge clk);
      m_valid = 1; m_en = 1; m_sel = 1;
      @(posedge clk);
      #1;
      check("min accept ngate", m_ngate, 2'b00);
      check("min accept busy", m_busy, 1'b1);
      @(negedge clk);
      m_valid = 0;
      @(posedge clk);
      #1;
      check("min make ngate", m_ngate, 2'b10);
      check("min make connected", m_connected, 1'b1);
      check("min make busy", m_busy, 1'b0);
      @(negedge clk);
      m_valid = 1; m_en = 1; m_sel = 0;
      @(posedge clk);
      #1 check("min switch break ngate", m_ngate, 2'b00);
      @(negedge clk);
      m_valid = 0;
      @(posedge clk);
      #1;
      check("min switch make ngate", m_ngate, 2'b01);
      check("min switch active_sel", m_active_sel, 1'b0);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/tgate_switch_seq.md
TGATE_SWITCH_SEQ -- requirements
Module: tgate_switch_seq

Interface
REQ-001 The block SHALL have parameter DEAD_CYC, default 3, meaning the number of all-off dead-time cycles; legal range is 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req_valid, input, 1 bit: a switch request is present.
REQ-005 The block SHALL have port req_sel, input, 1 bit: the target channel, 0 or 1.
REQ-006 The block SHALL have port req_en, input, 1 bit: 1 means connect the target channel, 0 means disconnect all channels.
REQ-007 The block SHALL have port req_ready, output, 1 bit: the block can accept a request this cycle.
REQ-008 The block SHALL have port ngate, output, 2 bits: nmos control per channel, active-high.
REQ-009 The block SHALL have port pgate, output, 2 bits: pmos control per channel, active-low.
REQ-010 The block SHALL have port active_sel, output, 1 bit: the channel currently connected, or last targeted.
REQ-011 The block SHALL have port connected, output, 1 bit: a channel is conducting.
REQ-012 The block SHALL have port busy, output, 1 bit: the dead-time interval is in progress.

Function
REQ-013 The block SHALL implement three states: OFF, BREAK and ON.
REQ-014 All outputs SHALL be registered, with pgate[i] equal to ~ngate[i] on every cycle, so there is no complementary skew between the two gates of a channel.
REQ-015 ngate SHALL never equal 2'b11 on any cycle.
REQ-016 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
REQ-017 req_ready SHALL be 1 in OFF and ON, and 0 in BREAK; a request presented during BREAK SHALL be held off, not dropped.
REQ-018 An accepted connect request (req_en=1) from OFF, or from ON with a different req_sel, SHALL do all of the following on the accepting edge:
  - drive ngate to 00;
  - latch active_sel to req_sel;
  - load the dead-time counter with DEAD_CYC-1;
  - enter BREAK.
REQ-019 In BREAK, a counter value of 0 at a rising edge SHALL take the block to ON with ngate[active_sel] set to 1; a nonzero value SHALL decrement by 1.
REQ-020 ngate SHALL therefore be 00 for exactly DEAD_CYC cycles between the accepting edge and the make edge; the make edge is the accepting edge plus DEAD_CYC.
REQ-021 An accepted redundant request (ON with req_en=1 and req_sel equal to active_sel) SHALL cause no output change and SHALL leave the gates conducting without a glitch.
REQ-022 An accepted disconnect request (req_en=0) from ON SHALL drive ngate to 00 and enter OFF on the accepting edge, with no dead time, while active_sel holds its value.
REQ-023 An accepted disconnect request in OFF SHALL be a no-op.
REQ-024 connected SHALL be 1 only in ON, and busy SHALL be 1 only in BREAK.
REQ-025 The dead-time counter SHALL be 4 bits wide and SHALL never wrap; it SHALL only be loaded on an accept and decremented in BREAK.
REQ-026 Any state reached through an illegal encoding SHALL return to OFF on the next edge, with ngate at 00.

Reset
REQ-027 Assertion of rstn (low) SHALL immediately and asynchronously force:
  - state OFF;
  - ngate 00, pgate 11;
  - active_sel 0, connected 0, busy 0;
  - the counter to 0.
REQ-028 req_ready SHALL be 1 during and after reset.
REQ-029 Reset asserted mid-BREAK or mid-ON SHALL abort the operation with no make edge afterward.
REQ-030 Release of rstn SHALL take effect synchronously on the next rising edge, with no request accepted on that edge.

Verification
REQ-031 Scenario (connect): with DEAD_CYC=3, after reset, req_valid=1, req_en=1, req_sel=1 for one cycle -> the response SHALL be:
  - busy=1 for 3 cycles;
  - ngate=10 and pgate=01 from accept+3;
  - connected=1.
REQ-032 Scenario (switch): from ON on channel 1, request req_sel=0 with req_en=1 -> the response SHALL be:
  - ngate=00 for exactly 3 cycles;
  - then ngate=01;
  - 11 never observed on ngate.
REQ-033 Scenario (redundant and held-off): request the same channel while ON -> ngate, pgate and busy SHALL be unchanged. Separately, hold req_valid high during BREAK -> req_ready SHALL be 0, with the request accepted on the first ON cycle.
REQ-034 Scenario (disconnect): from ON on channel 0, req_en=0 -> the response SHALL be:
  - ngate=00 and pgate=11 on the accepting edge;
  - connected=0 and busy=0 throughout;
  - active_sel=0.
REQ-035 Scenario (reset mid-BREAK): drop rstn during BREAK -> all outputs SHALL be at their reset values immediately, without waiting for a clock edge, with no later make edge, and after release a fresh request SHALL see the full DEAD_CYC dead time.
REQ-036 Scenario (minimum dead time): with DEAD_CYC=1, connect from OFF -> ngate SHALL go to 00 at the accepting edge and the channel SHALL turn on at accept+1.
REQ-037 The bench SHALL check continuously, on every cycle, that pgate equals ~ngate and that ngate is never 11.
